// File: rtl/adder_arb_pkg.sv
// adder_arb_pkg: shared types and helpers for the adder arbiter slice.
//   tag_t    : {valid, id} travelling alongside an operation through the adder.
//   id_w()   : requester ID width for a given requester count.
//   adder_lat(): adder latency in cycles for a given pipeline configuration.
package adder_arb_pkg;

  // Widest ID needed for the largest supported requester count (16).
  localparam int unsigned ID_MAX_W = 4;

  typedef struct packed {
    logic                valid;
    logic [ID_MAX_W-1:0] id;
  } tag_t;

  function automatic int unsigned id_w(input int unsigned num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

  function automatic int unsigned adder_lat(input int unsigned pipeline_en,
                                            input int unsigned pipeline_stages);
    return (pipeline_en != 0) ? pipeline_stages : 0;
  endfunction

endpackage

// File: rtl/adder_arb_rr_pick.sv
// adder_arb_rr_pick: combinational rotate-priority picker.
// Grants the first set bit of req found searching upward from ptr+1,
// wrapping NUM_REQ-1 -> 0. Output is one-hot plus the encoded index.
module adder_arb_rr_pick
  import adder_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = id_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_id,
  output logic               gnt_any
);

  // Scan the requesters in rotated order and keep the first hit.
  always_comb begin
    gnt     = '0;
    gnt_id  = '0;
    gnt_any = 1'b0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      logic [ID_W-1:0] idx;
      idx = ID_W'((32'(ptr) + k) % NUM_REQ);
      if (!gnt_any && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_id   = idx;
        gnt_any  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/adder_arbiter.sv
// adder_arbiter: shares one adder among NUM_REQ valid/ready requesters.
// Round-robin grant -> one registered issue stage -> adder; an ID tag pipeline
// matching the adder latency routes each result back as a one-cycle strobe.
// The adder has no backpressure, so results are never stalled.
// Optional build macro: ADDER_ARB_HIPRI_EN -- requester 0 becomes strict high
// priority (its grants do not move the round-robin pointer).
module adder_arbiter
  import adder_arb_pkg::*;
#(
  parameter  int unsigned NUM_REQ         = 4,
  parameter  int unsigned DATA_WIDTH      = 32,
  parameter  int unsigned PIPELINE_EN     = 0,
  parameter  int unsigned PIPELINE_STAGES = 1,
  localparam int unsigned LAT             = adder_lat(PIPELINE_EN, PIPELINE_STAGES),
  localparam int unsigned CNT_W           = $clog2(LAT + 2)
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               arb_en,
  input  logic [NUM_REQ-1:0]                 req_valid,
  output logic [NUM_REQ-1:0]                 req_ready,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_a,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_b,
  output logic                               add_valid_in,
  output logic [DATA_WIDTH-1:0]              add_a,
  output logic [DATA_WIDTH-1:0]              add_b,
  input  logic                               add_valid_out,
  input  logic [DATA_WIDTH-1:0]              add_sum,
  input  logic                               add_carry,
  output logic [NUM_REQ-1:0]                 rsp_valid,
  output logic [DATA_WIDTH-1:0]              rsp_sum,
  output logic                               rsp_carry,
  output logic [CNT_W-1:0]                   inflight,
  output logic                               tag_err
);

  localparam int unsigned ID_W = id_w(NUM_REQ);

  logic [ID_W-1:0]    ptr;
  logic [NUM_REQ-1:0] rr_req;
  logic [NUM_REQ-1:0] rr_gnt;
  logic [ID_W-1:0]    rr_id;
  logic               rr_any;
  logic               grant_any;
  logic [ID_W-1:0]    grant_id;
  logic               ptr_upd;
  tag_t               issue_tag;
  tag_t               exit_tag;

`ifdef ADDER_ARB_HIPRI_EN
  // Requester 0 is served outside the rotation.
  assign rr_req = req_valid & {{(NUM_REQ-1){1'b1}}, 1'b0};
`else
  assign rr_req = req_valid;
`endif

  adder_arb_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .req     (rr_req),
    .ptr     (ptr),
    .gnt     (rr_gnt),
    .gnt_id  (rr_id),
    .gnt_any (rr_any)
  );

  // Grant selection; ready is held low during reset and when arbitration is off.
  always_comb begin
    req_ready = '0;
    grant_any = 1'b0;
    grant_id  = '0;
    ptr_upd   = 1'b0;
    if (rst_n && arb_en) begin
`ifdef ADDER_ARB_HIPRI_EN
      if (req_valid[0]) begin
        req_ready[0] = 1'b1;
        grant_any    = 1'b1;
      end else if (rr_any) begin
        req_ready = rr_gnt;
        grant_any = 1'b1;
        grant_id  = rr_id;
        ptr_upd   = 1'b1;
      end
`else
      if (rr_any) begin
        req_ready = rr_gnt;
        grant_any = 1'b1;
        grant_id  = rr_id;
        ptr_upd   = 1'b1;
      end
`endif
    end
  end

  // Issue stage: capture granted operands and ID; operands hold when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_tag <= '0;
      add_a     <= '0;
      add_b     <= '0;
      ptr       <= ID_W'(NUM_REQ - 1);
    end else begin
      issue_tag.valid <= grant_any;
      if (grant_any) begin
        issue_tag.id <= ID_MAX_W'(grant_id);
        add_a        <= req_a[grant_id];
        add_b        <= req_b[grant_id];
      end
      if (ptr_upd) begin
        ptr <= grant_id;
      end
    end
  end

  assign add_valid_in = issue_tag.valid;

  // Tag pipeline tracking the adder latency; zero latency taps the issue stage.
  generate
    if (LAT == 0) begin : g_nolat
      assign exit_tag = issue_tag;
    end else begin : g_lat
      tag_t tag_q [LAT];

      // Shift {valid,id} in lockstep with the adder registers.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int unsigned s = 0; s < LAT; s++) begin
            tag_q[s] <= '0;
          end
        end else begin
          tag_q[0] <= issue_tag;
          for (int unsigned s = 1; s < LAT; s++) begin
            tag_q[s] <= tag_q[s-1];
          end
        end
      end

      assign exit_tag = tag_q[LAT-1];
    end
  endgenerate

  // Route a result to its originator only when tag and adder agree.
  always_comb begin
    rsp_valid = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (exit_tag.id == ID_MAX_W'(i)) begin
        rsp_valid[i] = exit_tag.valid & add_valid_out;
      end
    end
  end

  assign rsp_sum   = add_sum;
  assign rsp_carry = add_carry;

  // Sticky flag for any disagreement between tag pipeline and adder valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_err <= 1'b0;
    end else if (exit_tag.valid ^ add_valid_out) begin
      tag_err <= 1'b1;
    end
  end

  // Count operations between grant and tag exit, saturating at both ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= '0;
    end else begin
      case ({grant_any, exit_tag.valid})
        2'b10: if (inflight != '1) inflight <= inflight + CNT_W'(1);
        2'b01: if (inflight != '0) inflight <= inflight - CNT_W'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_arbiter.sv
// tb_adder_arbiter: two arbiters share the requester inputs -- one in front of a
// 2-stage registered adder model, one in front of a combinational adder model.
// A scoreboard of expected responses (due cycle, requester, 33-bit result) is
// built from the round-robin rule and plain addition.
module tb_adder_arbiter;

  localparam int N = 4;
  localparam int W = 32;
`ifdef ADDER_ARB_HIPRI_EN
  localparam logic HIPRI = 1'b1;
`else
  localparam logic HIPRI = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic arb_en = 1'b0;
  logic [N-1:0] req_valid = '0;
  logic [N-1:0][W-1:0] req_a = '0;
  logic [N-1:0][W-1:0] req_b = '0;
  logic f_vo = 1'b0;

  // DUT with LAT=2
  logic [N-1:0] rdy1, rsp_v1;
  logic avi1, avo1, c1, rsp_c1, terr1;
  logic [W-1:0] aa1, ab1, s1, rsp_s1;
  logic [1:0] infl1;
  // DUT with LAT=0
  logic [N-1:0] rdy0, rsp_v0;
  logic avi0, avo0, c0, rsp_c0, terr0;
  logic [W-1:0] aa0, ab0, s0, rsp_s0;
  logic [0:0] infl0;

  always #5 clk = ~clk;

  adder_arbiter #(.NUM_REQ(N), .DATA_WIDTH(W), .PIPELINE_EN(1), .PIPELINE_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .arb_en(arb_en), .req_valid(req_valid), .req_ready(rdy1),
    .req_a(req_a), .req_b(req_b), .add_valid_in(avi1), .add_a(aa1), .add_b(ab1),
    .add_valid_out(avo1), .add_sum(s1), .add_carry(c1), .rsp_valid(rsp_v1),
    .rsp_sum(rsp_s1), .rsp_carry(rsp_c1), .inflight(infl1), .tag_err(terr1));

  adder_arbiter #(.NUM_REQ(N), .DATA_WIDTH(W), .PIPELINE_EN(0), .PIPELINE_STAGES(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .arb_en(arb_en), .req_valid(req_valid), .req_ready(rdy0),
    .req_a(req_a), .req_b(req_b), .add_valid_in(avi0), .add_a(aa0), .add_b(ab0),
    .add_valid_out(avo0), .add_sum(s0), .add_carry(c0), .rsp_valid(rsp_v0),
    .rsp_sum(rsp_s0), .rsp_carry(rsp_c0), .inflight(infl0), .tag_err(terr0));

  // Two-stage registered adder model (reset with the arbiter), optional forced valid.
  logic [1:0]  am_v;
  logic [32:0] am_r0, am_r1;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      am_v <= '0; am_r0 <= '0; am_r1 <= '0;
    end else begin
      am_v  <= {am_v[0], avi1};
      am_r0 <= {1'b0, aa1} + {1'b0, ab1};
      am_r1 <= am_r0;
    end
  end
  assign avo1 = am_v[1] | f_vo;
  assign {c1, s1} = am_r1;

  // Combinational adder model.
  assign avo0 = avi0;
  assign {c0, s0} = {1'b0, aa0} + {1'b0, ab0};

  // ---------------- reference model / scoreboard ----------------
  typedef struct { int due; int id; logic [32:0] res; } exp_t;
  exp_t q1[$];
  exp_t q0[$];
  int cyc = 0;
  int m_ptr = N - 1;
  int n_tests = 0;
  int n_fail = 0;

  logic fix_en = 1'b0;
  logic [W-1:0] fix_a = '0, fix_b = '0;

  logic [N-1:0] exp_ready, obs_ready1, obs_ready0;
  logic [N-1:0] exp_rsp1, obs_rsp1, exp_rsp0, obs_rsp0;
  logic [32:0]  exp_res1, obs_res1, exp_res0, obs_res0;
  int exp_infl1, exp_infl0;
  logic [1:0] obs_infl1;
  logic [0:0] obs_infl0;
  logic obs_terr1, obs_terr0;

  function automatic int model_grant(input logic [N-1:0] v, input logic arb);
    if (!arb) return -1;
    if (HIPRI && v[0]) return 0;
    for (int k = 1; k <= N; k++) begin
      int i;
      i = (m_ptr + k) % N;
      if (HIPRI && i == 0) continue;
      if (v[i]) return i;
    end
    return -1;
  endfunction

  // Drive one cycle at the negedge, sample observed and expected values, then advance.
  task automatic drive_cycle(input logic [N-1:0] v, input logic arb);
    int g;
    @(negedge clk);
    req_valid = v;
    arb_en = arb;
    for (int i = 0; i < N; i++) begin
      req_a[i] = fix_en ? fix_a : $urandom;
      req_b[i] = fix_en ? fix_b : $urandom;
    end
    #1;
    g = model_grant(v, arb);
    exp_ready = (g >= 0) ? N'(1 << g) : '0;
    exp_rsp1 = '0; exp_res1 = '0; exp_rsp0 = '0; exp_res0 = '0;
    if (q1.size() > 0 && q1[0].due == cyc) begin
      exp_rsp1 = N'(1 << q1[0].id); exp_res1 = q1[0].res;
    end
    if (q0.size() > 0 && q0[0].due == cyc) begin
      exp_rsp0 = N'(1 << q0[0].id); exp_res0 = q0[0].res;
    end
    exp_infl1 = q1.size();
    exp_infl0 = q0.size();
    obs_ready1 = rdy1; obs_ready0 = rdy0;
    obs_rsp1 = rsp_v1; obs_res1 = {rsp_c1, rsp_s1};
    obs_rsp0 = rsp_v0; obs_res0 = {rsp_c0, rsp_s0};
    obs_infl1 = infl1; obs_infl0 = infl0;
    obs_terr1 = terr1; obs_terr0 = terr0;
    if (exp_rsp1 != '0) void'(q1.pop_front());
    if (exp_rsp0 != '0) void'(q0.pop_front());
    if (g >= 0) begin
      q1.push_back('{cyc + 3, g, {1'b0, req_a[g]} + {1'b0, req_b[g]}});
      q0.push_back('{cyc + 1, g, {1'b0, req_a[g]} + {1'b0, req_b[g]}});
      if (!(HIPRI && g == 0)) m_ptr = g;
    end
    @(posedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req_valid = '0; arb_en = 1'b0; f_vo = 1'b0; fix_en = 1'b0;
    q1.delete(); q0.delete(); m_ptr = N - 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0; req_valid = 4'hF; arb_en = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_tests++; if (rdy1 !== 4'h0 || rdy0 !== 4'h0) begin n_fail++; $display("FAIL reset_ready: got %b/%b exp 0000", rdy1, rdy0); end
    n_tests++; if (avi1 !== 1'b0 || aa1 !== '0 || ab1 !== '0) begin n_fail++; $display("FAIL reset_issue: got v=%b a=%h b=%h exp 0", avi1, aa1, ab1); end
    n_tests++; if (rsp_v1 !== 4'h0 || rsp_v0 !== 4'h0) begin n_fail++; $display("FAIL reset_rsp: got %b/%b exp 0000", rsp_v1, rsp_v0); end
    n_tests++; if (infl1 !== 2'd0 || infl0 !== 1'b0 || terr1 !== 1'b0) begin n_fail++; $display("FAIL reset_cnt: got infl=%0d terr=%b exp 0", infl1, terr1); end
    do_reset();
  endtask

  task automatic test_rr_order();
    for (int k = 0; k < 11; k++) begin
      logic [N-1:0] e_rdy, e_rsp;
      drive_cycle(k < 8 ? 4'hF : 4'h0, 1'b1);
      e_rdy = (k < 8) ? N'(1 << (k % 4)) : '0;
      e_rsp = (k >= 3) ? N'(1 << ((k - 3) % 4)) : '0;
      n_tests++; if (obs_ready1 !== e_rdy) begin n_fail++; $display("FAIL rr_grant[%0d]: got %b exp %b", k, obs_ready1, e_rdy); end
      n_tests++; if (obs_rsp1 !== e_rsp) begin n_fail++; $display("FAIL rr_rsp[%0d]: got %b exp %b", k, obs_rsp1, e_rsp); end
      n_tests++; if (e_rsp != '0 && obs_res1 !== exp_res1) begin n_fail++; $display("FAIL rr_sum[%0d]: got %h exp %h", k, obs_res1, exp_res1); end
      n_tests++; if (int'(obs_infl1) != exp_infl1) begin n_fail++; $display("FAIL rr_inflight[%0d]: got %0d exp %0d", k, obs_infl1, exp_infl1); end
    end
  endtask

  task automatic test_carry();
    fix_en = 1'b1; fix_a = 32'hFFFF_FFFF; fix_b = 32'h1;
    for (int k = 0; k < 4; k++) begin
      drive_cycle(k == 0 ? 4'b0100 : 4'b0000, 1'b1);
      if (k == 1) begin
        n_tests++; if (obs_rsp0 !== 4'b0100 || obs_res0 !== 33'h1_0000_0000) begin n_fail++; $display("FAIL carry_lat0: got %b %h exp 0100 100000000", obs_rsp0, obs_res0); end
      end
      if (k == 3) begin
        n_tests++; if (obs_rsp1 !== 4'b0100 || obs_res1 !== 33'h1_0000_0000) begin n_fail++; $display("FAIL carry_lat2: got %b %h exp 0100 100000000", obs_rsp1, obs_res1); end
      end
    end
    fix_en = 1'b0;
  endtask

  task automatic test_nolat();
    for (int k = 0; k < 3; k++) begin
      logic [0:0] e_inf;
      logic [N-1:0] e_rsp;
      drive_cycle(k == 0 ? 4'b0010 : 4'b0000, 1'b1);
      e_inf = (k == 1) ? 1'b1 : 1'b0;
      e_rsp = (k == 1) ? 4'b0010 : 4'b0000;
      n_tests++; if (obs_infl0 !== e_inf) begin n_fail++; $display("FAIL nolat_inflight[%0d]: got %0d exp %0d", k, obs_infl0, e_inf); end
      n_tests++; if (obs_rsp0 !== e_rsp) begin n_fail++; $display("FAIL nolat_rsp[%0d]: got %b exp %b", k, obs_rsp0, e_rsp); end
      n_tests++; if (e_rsp != '0 && obs_res0 !== exp_res0) begin n_fail++; $display("FAIL nolat_sum: got %h exp %h", obs_res0, exp_res0); end
    end
    repeat (3) drive_cycle(4'h0, 1'b1);
  endtask

  task automatic test_drain();
    int got;
    got = 0;
    for (int k = 0; k < 8; k++) begin
      drive_cycle(4'hF, k < 3);
      if (k >= 3) begin
        n_tests++; if (obs_ready1 !== 4'h0) begin n_fail++; $display("FAIL drain_ready[%0d]: got %b exp 0000", k, obs_ready1); end
      end
      n_tests++; if (obs_rsp1 !== exp_rsp1) begin n_fail++; $display("FAIL drain_rsp[%0d]: got %b exp %b", k, obs_rsp1, exp_rsp1); end
      got += $countones(obs_rsp1);
    end
    n_tests++; if (got != 3) begin n_fail++; $display("FAIL drain_count: got %0d exp 3", got); end
    n_tests++; if (infl1 !== 2'd0) begin n_fail++; $display("FAIL drain_inflight: got %0d exp 0", infl1); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 200; k++) begin
      drive_cycle(N'($urandom), ($urandom % 8) != 0);
      n_tests++; if (obs_ready1 !== exp_ready || obs_ready0 !== exp_ready) begin n_fail++; $display("FAIL rand_ready[%0d]: got %b/%b exp %b", k, obs_ready1, obs_ready0, exp_ready); end
      n_tests++; if (obs_rsp1 !== exp_rsp1 || obs_rsp0 !== exp_rsp0) begin n_fail++; $display("FAIL rand_rsp[%0d]: got %b/%b exp %b/%b", k, obs_rsp1, obs_rsp0, exp_rsp1, exp_rsp0); end
      n_tests++; if ((exp_rsp1 != '0 && obs_res1 !== exp_res1) || (exp_rsp0 != '0 && obs_res0 !== exp_res0)) begin n_fail++; $display("FAIL rand_sum[%0d]: got %h/%h exp %h/%h", k, obs_res1, obs_res0, exp_res1, exp_res0); end
      n_tests++; if (int'(obs_infl1) != exp_infl1 || int'(obs_infl0) != exp_infl0) begin n_fail++; $display("FAIL rand_inflight[%0d]: got %0d/%0d exp %0d/%0d", k, obs_infl1, obs_infl0, exp_infl1, exp_infl0); end
      n_tests++; if (obs_terr1 !== 1'b0 || obs_terr0 !== 1'b0) begin n_fail++; $display("FAIL rand_tag_err[%0d]: got %b/%b exp 0", k, obs_terr1, obs_terr0); end
    end
    repeat (4) drive_cycle(4'h0, 1'b1);
  endtask

  task automatic test_tag_err();
    @(negedge clk);
    f_vo = 1'b1;
    #1;
    n_tests++; if (rsp_v1 !== 4'h0) begin n_fail++; $display("FAIL tagerr_rsp: got %b exp 0000", rsp_v1); end
    @(negedge clk);
    f_vo = 1'b0;
    repeat (3) begin
      @(negedge clk); #1;
      n_tests++; if (terr1 !== 1'b1) begin n_fail++; $display("FAIL tagerr_sticky: got %b exp 1", terr1); end
    end
    do_reset();
    #1;
    n_tests++; if (terr1 !== 1'b0) begin n_fail++; $display("FAIL tagerr_clear: got %b exp 0", terr1); end
  endtask

  task automatic test_hipri();
    do_reset();
    for (int k = 0; k < 6; k++) begin
      logic [N-1:0] e;
      drive_cycle(4'b1001, 1'b1);
      e = HIPRI ? 4'b0001 : ((k % 2 == 0) ? 4'b0001 : 4'b1000);
      n_tests++; if (obs_ready1 !== e) begin n_fail++; $display("FAIL hipri_grant[%0d]: got %b exp %b", k, obs_ready1, e); end
    end
    drive_cycle(4'b1000, 1'b1);
    n_tests++; if (obs_ready1 !== 4'b1000) begin n_fail++; $display("FAIL hipri_drop0: got %b exp 1000", obs_ready1); end
    repeat (2) drive_cycle(4'hF, 1'b1);
    // asynchronous reset in the middle of a cycle with operations in flight
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++; if (rsp_v1 !== 4'h0 || infl1 !== 2'd0 || rdy1 !== 4'h0) begin n_fail++; $display("FAIL midrst_clear: got rsp=%b infl=%0d rdy=%b exp 0", rsp_v1, infl1, rdy1); end
    do_reset();
    for (int k = 0; k < 6; k++) begin
      drive_cycle(4'h0, 1'b1);
      n_tests++; if (obs_rsp1 !== 4'h0 || obs_rsp0 !== 4'h0 || obs_terr1 !== 1'b0) begin n_fail++; $display("FAIL midrst_stale[%0d]: got %b/%b terr=%b exp 0", k, obs_rsp1, obs_rsp0, obs_terr1); end
    end
  endtask

  initial begin
    test_reset();
    test_rr_order();
    test_carry();
    test_nolat();
    test_drain();
    test_random();
    test_tag_err();
    test_hipri();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
